// File: rtl/unsigned_calc_checker_v.sv
// unsigned_calc_checker_v: exhaustive sweep checker for a 4-bit unsigned calculator, f = 7a - 3b + 6c (mod 256).
// Latency: each vector costs SETTLE_CYCLES+2 clocks; a full sweep completes 4096*(SETTLE_CYCLES+2)+1 clocks after start.
// Backpressure: none; i_start is ignored while busy. Define CALC_CHK_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module unsigned_calc_checker_v #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   output logic [3:0]  o_au,
   output logic [3:0]  o_bu,
   output logic [3:0]  o_cu,
   input  logic [7:0]  i_fu,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_pass,
   output logic [12:0] o_err_cnt,
   output logic [11:0] o_fail_vec,
   output logic [7:0]  o_fail_got
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRIVE   = 3'd1,
      SETTLE  = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [11:0] idx;
   logic [3:0]  settle_cnt;
   logic        fail_seen;
   logic [7:0]  expected;
   logic        mismatch;
   logic        last_vec;
   logic        settle_last;
   logic        stop_now;

   // Golden result for the operands currently on the bus; 8-bit arithmetic gives the mod-256 wrap for free
   always_comb begin
      expected    = (8'd7 * {4'd0, o_au}) - (8'd3 * {4'd0, o_bu}) + (8'd6 * {4'd0, o_cu});
      mismatch    = (i_fu != expected);
      last_vec    = (idx == 12'hFFF);
      settle_last = (settle_cnt == 4'(SETTLE_CYCLES - 1));
`ifdef CALC_CHK_STOP_ON_FAIL_EN
      stop_now    = last_vec || mismatch;
`else
      stop_now    = last_vec;
`endif
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status decode; start is only honoured from IDLE or DONE
   always_comb begin
      state_nxt = state;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) state_nxt = DRIVE;
         end
         DRIVE: begin
            o_busy    = 1'b1;
            state_nxt = SETTLE;
         end
         SETTLE: begin
            o_busy = 1'b1;
            if (settle_last) state_nxt = COMPARE;
         end
         COMPARE: begin
            o_busy    = 1'b1;
            state_nxt = stop_now ? DONE : DRIVE;
         end
         DONE: begin
            o_done = 1'b1;
            if (i_start) state_nxt = DRIVE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      o_pass = o_done && (o_err_cnt == 13'd0);
   end

   // Sweep datapath: vector index, operand bus, settle timer and result capture
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx        <= 12'd0;
         settle_cnt <= 4'd0;
         fail_seen  <= 1'b0;
         o_au       <= 4'd0;
         o_bu       <= 4'd0;
         o_cu       <= 4'd0;
         o_err_cnt  <= 13'd0;
         o_fail_vec <= 12'd0;
         o_fail_got <= 8'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  idx        <= 12'd0;
                  fail_seen  <= 1'b0;
                  o_err_cnt  <= 13'd0;
                  o_fail_vec <= 12'd0;
                  o_fail_got <= 8'd0;
               end
            end
            DRIVE: begin
               {o_au, o_bu, o_cu} <= idx;
               settle_cnt         <= 4'd0;
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 4'd1;
            end
            COMPARE: begin
               if (mismatch) begin
                  o_err_cnt <= o_err_cnt + 13'd1;
                  if (!fail_seen) begin
                     fail_seen  <= 1'b1;
                     o_fail_vec <= idx;
                     o_fail_got <= i_fu;
                  end
               end
               if (!stop_now) idx <= idx + 12'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unsigned_calc_checker_v.sv
// tb_unsigned_calc_checker_v: drives the checker with a behavioural calculator that can inject faults per vector.
// Golden points, a single known fault, random faults, restart from DONE and mid-sweep reset are exercised.
// Expected counts, first-fail capture and sweep length come from a plain-arithmetic model of the rules.
module tb_unsigned_calc_checker_v;

   localparam int SETTLE     = 2;
   localparam int VEC_CYCLES = SETTLE + 2;
   localparam int FULL_SWEEP = 4096 * VEC_CYCLES + 1;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  au, bu, cu;
   logic [7:0]  fu = 8'd0;
   logic        busy, done, pass;
   logic [12:0] err_cnt;
   logic [11:0] fail_vec;
   logic [7:0]  fail_got;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   unsigned_calc_checker_v #(.SETTLE_CYCLES(SETTLE)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .o_au       (au),
      .o_bu       (bu),
      .o_cu       (cu),
      .i_fu       (fu),
      .o_busy     (busy),
      .o_done     (done),
      .o_pass     (pass),
      .o_err_cnt  (err_cnt),
      .o_fail_vec (fail_vec),
      .o_fail_got (fail_got)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] c;
      logic [7:0] f;
   } gold_t;

   gold_t gold [4];

   bit          fault_on  [4096];
   logic [7:0]  fault_val [4096];

   function automatic logic [7:0] ref_f(input int idx);
      int a, b, c, v;
      a = idx / 256;
      b = (idx / 16) % 16;
      c = idx % 16;
      v = (7 * a - 3 * b + 6 * c) % 256;
      if (v < 0) v += 256;
      return v[7:0];
   endfunction

   task automatic check(input string name, input longint got, input longint want);
      total++;
      if (got == want) passed++;
      else $display("FAIL %s: got %0d, want %0d", name, got, want);
   endtask

   // Behavioural calculator: correct result unless this vector carries an override
   logic [11:0] calc_idx;
   always @(negedge clk) begin
      calc_idx = {au, bu, cu};
      fu = fault_on[calc_idx] ? fault_val[calc_idx] : ref_f(int'(calc_idx));
   end

   // Bus monitor: ascending order, per-vector hold time and error count around each vector
   bit          mon_en = 1'b0;
   logic [11:0] mon_v;
   logic [11:0] prev_v;
   logic [11:0] sweep_s0;
   int changes, order_err, hold_err, since;
   int err_first [4096];
   int err_last  [4096];

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         mon_v = {au, bu, cu};
         if (busy && mon_v != prev_v) begin
            changes++;
            if (changes == 1) begin
               if (mon_v != ((sweep_s0 == 12'd0) ? 12'd1 : 12'd0)) order_err++;
            end else begin
               if (mon_v != prev_v + 12'd1) order_err++;
               if (since != VEC_CYCLES) hold_err++;
            end
            since = 0;
            err_first[mon_v] = int'(err_cnt);
            prev_v = mon_v;
         end
         since++;
         err_last[mon_v] = int'(err_cnt);
      end
   end

   task automatic clear_faults();
      for (int i = 0; i < 4096; i++) begin
         fault_on[i]  = 1'b0;
         fault_val[i] = 8'd0;
      end
      // Golden points are served from the table, not from the model
      for (int g = 0; g < 4; g++) begin
         fault_on[{gold[g].a, gold[g].b, gold[g].c}]  = 1'b1;
         fault_val[{gold[g].a, gold[g].b, gold[g].c}] = gold[g].f;
      end
   endtask

   task automatic run_sweep(input bit hold_start, output int cycles);
      sweep_s0  = {au, bu, cu};
      prev_v    = sweep_s0;
      changes   = 0;
      order_err = 0;
      hold_err  = 0;
      since     = 0;
      mon_en    = 1'b1;
      @(negedge clk);
      start  = 1'b1;
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 1) begin
            check("start_clears_err", err_cnt, 0);
            check("start_clears_fail_vec", fail_vec, 0);
            check("busy_after_start", busy, 1);
            check("done_low_after_start", done, 0);
            if (!hold_start) start = 1'b0;
         end
      end while (!done && cycles < FULL_SWEEP + 100);
      start = 1'b0;
      check("sweep_reaches_done", done, 1);
      @(posedge clk);
      #2;
      mon_en = 1'b0;
   endtask

   task automatic check_results(input string tag, input int cycles);
      int exp_err, first, last, idx, delta;
      exp_err = 0;
      first   = -1;
      last    = 4095;
      for (int i = 0; i < 4096; i++) begin
         if (fault_on[i] && fault_val[i] != ref_f(i)) begin
            exp_err++;
            if (first < 0) first = i;
         end
      end
`ifdef CALC_CHK_STOP_ON_FAIL_EN
      if (first >= 0) begin
         last    = first;
         exp_err = 1;
      end
`endif
      check({tag, "_cycles"}, cycles, 1 + (last + 1) * VEC_CYCLES);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err_cnt"}, err_cnt, exp_err);
      check({tag, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
      check({tag, "_fail_vec"}, fail_vec, (first < 0) ? 0 : first);
      check({tag, "_fail_got"}, fail_got, (first < 0) ? 0 : int'(fault_val[first]));
      check({tag, "_order"}, order_err, 0);
      check({tag, "_hold"}, hold_err, 0);
      check({tag, "_vectors"}, changes, last + ((sweep_s0 == 12'd0) ? 0 : 1));
      for (int g = 0; g < 4; g++) begin
         idx = int'({gold[g].a, gold[g].b, gold[g].c});
         if (idx <= last) begin
            delta = (fault_val[idx] != ref_f(idx)) ? 1 : 0;
            check({tag, "_golden_delta"}, err_last[idx] - err_first[idx], delta);
         end
      end
   endtask

   int cyc;
   int n_rand, added, r_idx;

   initial begin
      gold[0] = '{4'd1,  4'd2,  4'd4,  8'h19};
      gold[1] = '{4'd15, 4'd15, 4'd15, 8'h96};
      gold[2] = '{4'd15, 4'd0,  4'd15, 8'hC3};
      gold[3] = '{4'd0,  4'd15, 4'd0,  8'hD3};
      clear_faults();

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_operands", {au, bu, cu}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("idle_no_self_start", busy | done, 0);

      // Single fault at (1,2,4) returning 0
      fault_val[12'h124] = 8'h00;
      run_sweep(1'b0, cyc);
      check_results("fault124", cyc);
      check("fault124_err_is_1", err_cnt, 1);
      check("fault124_vec", fail_vec, 12'h124);
      check("fault124_got", fail_got, 8'h00);
      check("fault124_pass_low", pass, 0);

      // Random faults, restart from DONE with start held high throughout the sweep
      clear_faults();
      n_rand = $urandom_range(2, 6);
      added  = 0;
      while (added < n_rand) begin
         r_idx = $urandom_range(0, 4095);
         if (!fault_on[r_idx]) begin
            fault_on[r_idx]  = 1'b1;
            fault_val[r_idx] = ref_f(r_idx) ^ 8'($urandom_range(1, 255));
            added++;
         end
      end
      run_sweep(1'b1, cyc);
      check_results("random", cyc);

      // Clean sweep from DONE
      clear_faults();
      run_sweep(1'b0, cyc);
      check_results("clean", cyc);
      check("clean_pass", pass, 1);

      // Mid-sweep asynchronous reset around vector 2000
`ifndef CALC_CHK_STOP_ON_FAIL_EN
      fault_on[100]  = 1'b1;
      fault_val[100] = ref_f(100) ^ 8'h5A;
`endif
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8000) @(negedge clk);
      check("mid_busy", busy, 1);
`ifndef CALC_CHK_STOP_ON_FAIL_EN
      check("mid_err_seen", err_cnt, 1);
`endif
      #3 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_err_cnt", err_cnt, 0);
      check("arst_fail_vec", fail_vec, 0);
      check("arst_fail_got", fail_got, 0);
      check("arst_operands", {au, bu, cu}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_idle", busy | done, 0);
      clear_faults();
      run_sweep(1'b0, cyc);
      check_results("after_rst", cyc);
      check("after_rst_pass", pass, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
